output_drain_ctrl: RTL

OUTPUT_DRAIN_CTRL -- requirements
Module: output_drain_ctrl

---
 rtl/output_drain_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/output_drain_ctrl.sv
// output_drain_ctrl
// Drains `count` result words from the output buffer, starting at `base_addr`.
// The words leave through a small egress FIFO with a valid/ready handshake.
// Reads are throttled so that every word already requested always has a free
// FIFO slot waiting for it. A drain can therefore never overflow the FIFO,
// however long the downstream side stalls.
//
// Ports
//   clk, rst      clock; asynchronous active-high reset
//   start         one-cycle drain request, sampled only while idle
//   base_addr     first buffer address of the drain
//   count         words to drain; 0 completes immediately, >16 saturates to 16
//   busy          high while a drain is in progress
//   done          one-cycle pulse after the last word has been transferred
//   buf_rd_en     buffer read strobe
//   buf_rd_addr   buffer read address; holds its last value between reads
//   buf_rd_data   buffer read data, valid the cycle after buf_rd_en
//   out_data      egress word (FIFO head); zero while out_valid is low
//   out_valid     egress FIFO non-empty
//   out_ready     downstream accepts the word when out_valid is also high
//   out_last      high while the head is the final word of the drain
module output_drain_ctrl #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              buf_rd_en,
  output logic [ADDR_W-1:0] buf_rd_addr,
  input  logic [DATA_W-1:0] buf_rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam logic [ADDR_W:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [OCC_W:0]  DEPTH_L = (OCC_W + 1)'(FIFO_DEPTH);

  // Clamp the word count to the buffer size.
  function automatic logic [ADDR_W:0] sat_count(input logic [ADDR_W:0] c);
    return (c > MAX_CNT) ? MAX_CNT : c;
  endfunction

  typedef enum logic [1:0] {IDLE, READ, FLUSH} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     cnt_q;
  logic [ADDR_W:0]     rd_idx_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [ADDR_W-1:0]   last_addr_q;
  logic                rd_vld_p1;
  logic                rd_last_p1;
  logic                done_q;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]    occ_q;
  logic [DATA_W:0]     fifo_mem [FIFO_DEPTH];

  logic                start_ok;
  logic [OCC_W:0]      fill;
  logic                rd_fire;
  logic                rd_is_last;
  logic                push;
  logic                pop;
  logic [DATA_W:0]     head;

  // Occupancy is taken before this cycle's pop. The outstanding read counts
  // as if it had already been pushed, which reserves its FIFO slot.
  assign start_ok   = start && (count != '0);
  assign fill       = (OCC_W + 1)'(occ_q) + (OCC_W + 1)'(rd_vld_p1);
  assign rd_fire    = (state_q == READ) && (fill < DEPTH_L);
  assign rd_is_last = (rd_idx_q == cnt_q - (ADDR_W + 1)'(1));

  assign push       = rd_vld_p1;
  assign head       = fifo_mem[rd_ptr_q];
  assign out_valid  = (occ_q != '0);
  assign out_data   = out_valid ? head[DATA_W-1:0] : '0;
  assign out_last   = out_valid & head[DATA_W];
  assign pop        = out_valid & out_ready;

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign buf_rd_en   = rd_fire;
  assign buf_rd_addr = rd_fire ? rd_addr_q : last_addr_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok) state_d = READ;
      READ:    if (rd_fire && rd_is_last) state_d = FLUSH;
      FLUSH:   if (pop && out_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- p0: FSM, read sequencing and buffer read issue ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rd_idx_q    <= '0;
      rd_addr_q   <= '0;
      last_addr_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= ((state_q == IDLE) && start && (count == '0)) ||
                 ((state_q == FLUSH) && pop && out_last);
      if ((state_q == IDLE) && start_ok) begin
        cnt_q     <= sat_count(count);
        rd_idx_q  <= '0;
        rd_addr_q <= base_addr;
      end else if (rd_fire) begin
        rd_idx_q    <= rd_idx_q + (ADDR_W + 1)'(1);
        rd_addr_q   <= rd_addr_q + ADDR_W'(1);
        last_addr_q <= rd_addr_q;
      end
    end
  end

  // ---- p1: in-flight read; buffer data arrives this cycle ----
  // The flag is cleared by reset, so a word that returns after an abort is
  // never pushed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld_p1  <= 1'b0;
      rd_last_p1 <= 1'b0;
    end else begin
      rd_vld_p1  <= rd_fire;
      rd_last_p1 <= rd_fire & rd_is_last;
    end
  end

  // ---- p2: egress FIFO ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Each entry stores the word together with its end-of-drain marker.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {rd_last_p1, buf_rd_data};
  end

endmodule
